// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter sharing one Cost table port among N_REQ search engines,
// with optional burst lock and a fixed-latency, requester-tagged return path.
module jam_cost_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [N_REQ-1:0]     LOCK,
  input  logic [3*N_REQ-1:0]   REQ_W,
  input  logic [3*N_REQ-1:0]   REQ_J,
  output logic [N_REQ-1:0]     GNT,
  output logic [2:0]           W,
  output logic [2:0]           J,
  input  logic [6:0]           Cost,
  output logic [N_REQ-1:0]     RSP_VALID,
  output logic [6:0]           RSP_COST,
  output logic                 BUSY
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]              ptr_q, ptr_d;
  logic [IW-1:0]              owner_q, owner_d;
  logic                       owner_vld_q, owner_vld_d;
  logic [ROM_LAT-1:0]         tag_vld_q, tag_vld_d;
  logic [ROM_LAT-1:0][IW-1:0] tag_id_q, tag_id_d;
  logic [2:0]                 w_q, w_d, j_q, j_d;
  logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [6:0]                 rsp_cost_q, rsp_cost_d;

  logic                       lock_hit;
  logic                       gnt_any;
  logic [IW-1:0]              gnt_idx;
  logic [IW-1:0]              cand [N_REQ];

  // A lock only holds while its owner is still requesting with LOCK asserted.
  assign lock_hit = owner_vld_q & REQ[owner_q] & LOCK[owner_q];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      cand[k] = IW'((int'(ptr_q) + k) % N_REQ);
    end
  end

  // Scan from the farthest candidate back to ptr so the closest requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    GNT     = '0;
    if (lock_hit) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (REQ[cand[k]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[k];
        end
      end
    end
    if (gnt_any) GNT[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = 1'b0;
    w_d         = w_q;
    j_d         = j_q;
    rsp_valid_d = '0;
    rsp_cost_d  = rsp_cost_q;
    if (gnt_any) begin
      ptr_d       = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      owner_d     = gnt_idx;
      owner_vld_d = LOCK[gnt_idx];
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_idx == IW'(i)) begin
          w_d = REQ_W[3*i +: 3];
          j_d = REQ_J[3*i +: 3];
        end
      end
    end
    // Tag pipeline mirrors the table latency; bubbles keep responses aligned.
    tag_vld_d[0] = gnt_any;
    tag_id_d[0]  = gnt_idx;
    for (int k = 1; k < ROM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
    if (tag_vld_q[ROM_LAT-1]) begin
      rsp_valid_d[tag_id_q[ROM_LAT-1]] = 1'b1;
      rsp_cost_d                       = Cost;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      w_q         <= '0;
      j_q         <= '0;
      rsp_valid_q <= '0;
      rsp_cost_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      w_q         <= w_d;
      j_q         <= j_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_cost_q  <= rsp_cost_d;
    end
  end

  assign W         = w_q;
  assign J         = j_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_COST  = rsp_cost_q;
  assign BUSY      = (|REQ) | (|tag_vld_q) | (|rsp_valid_q);

endmodule
